// File: rtl/shift_universal_pkg.sv
// shift_universal_pkg: mode encoding and sizing helper
// shared by the universal shift register and its stages.
package shift_universal_pkg;

  typedef enum logic [2:0] {
    HOLD       = 3'd0,
    SHIFT_UP   = 3'd1,
    SHIFT_DOWN = 3'd2,
    LOAD       = 3'd3,
    ROT_UP     = 3'd4,
    ROT_DOWN   = 3'd5,
    CLEAR      = 3'd6,
    RSVD       = 3'd7
  } mode_e;

  function automatic int fill_width(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/shift_universal_dff_vec.sv
// dff_vec: width_p-bit enabled register with synchronous
// active-low reset to reset_val_p.
module dff_vec #(
  parameter int                 width_p     = 8,
  parameter logic [width_p-1:0] reset_val_p = '0
) (
  input  logic               clk_i,
  input  logic               reset_n_i,
  input  logic               en_i,
  input  logic [width_p-1:0] d_i,
  output logic [width_p-1:0] q_o
);

  logic [width_p-1:0] r_q;

  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      r_q <= reset_val_p;
    end else if (en_i) begin
      r_q <= d_i;
    end
  end

  assign q_o = r_q;

endmodule

// File: rtl/shift_universal.sv
// shift_universal: depth_p x width_p universal shift register with fill count.
// Rotate modes only exist when SHIFT_UNIVERSAL_ROTATE_EN is defined.
module shift_universal
  import shift_universal_pkg::*;
#(
  parameter int                         width_p     = 8,
  parameter int                         depth_p     = 5,
  parameter logic [depth_p*width_p-1:0] reset_val_p = '0
) (
  input  logic                               clk_i,
  input  logic                               reset_n_i,
  input  logic [2:0]                         mode_i,
  input  logic [width_p-1:0]                 serial_lo_i,
  input  logic [width_p-1:0]                 serial_hi_i,
  input  logic [depth_p*width_p-1:0]         load_i,
  output logic [depth_p*width_p-1:0]         data_o,
  output logic [width_p-1:0]                 serial_lo_o,
  output logic [width_p-1:0]                 serial_hi_o,
  output logic [fill_width(depth_p)-1:0]     fill_o,
  output logic                               full_o
);

  localparam int             FW   = fill_width(depth_p);
  localparam logic [FW-1:0]  FULL = FW'(depth_p);
  localparam int             W    = width_p;
  localparam int             TOP  = depth_p - 1;

  logic [depth_p*W-1:0] w_q;
  logic                 w_shu;
  logic                 w_shd;
  logic                 w_rou;
  logic                 w_rod;
  logic                 w_ld;
  logic                 w_clr;
  logic                 w_en;
  logic [FW-1:0]        w_fill_nxt;
  logic [FW-1:0]        r_fill;

  // Unknown or reserved encodings fall to the default arm (HOLD).
  always_comb begin
    w_shu = 1'b0;
    w_shd = 1'b0;
    w_rou = 1'b0;
    w_rod = 1'b0;
    w_ld  = 1'b0;
    w_clr = 1'b0;
    case (mode_e'(mode_i))
      SHIFT_UP:   w_shu = 1'b1;
      SHIFT_DOWN: w_shd = 1'b1;
      LOAD:       w_ld  = 1'b1;
`ifdef SHIFT_UNIVERSAL_ROTATE_EN
      ROT_UP:     w_rou = 1'b1;
      ROT_DOWN:   w_rod = 1'b1;
`endif
      CLEAR:      w_clr = 1'b1;
      default:    ;
    endcase
  end

  assign w_en = w_shu | w_shd | w_rou | w_rod | w_ld | w_clr;

  for (genvar k = 0; k < depth_p; k++) begin : g_stage
    logic [W-1:0] w_cur;
    logic [W-1:0] w_up;
    logic [W-1:0] w_dn;
    logic [W-1:0] w_d;

    assign w_cur = w_q[k*W +: W];

    if (k == 0) begin : g_up0
      assign w_up = serial_lo_i;
    end else begin : g_upk
      assign w_up = w_q[(k-1)*W +: W];
    end

    if (k == TOP) begin : g_dnt
      assign w_dn = serial_hi_i;
    end else begin : g_dnk
      assign w_dn = w_q[(k+1)*W +: W];
    end

`ifdef SHIFT_UNIVERSAL_ROTATE_EN
    logic [W-1:0] w_ru;
    logic [W-1:0] w_rd;

    if (k == 0) begin : g_ru0
      assign w_ru = w_q[TOP*W +: W];
    end else begin : g_ruk
      assign w_ru = w_up;
    end

    if (k == TOP) begin : g_rdt
      assign w_rd = w_q[0 +: W];
    end else begin : g_rdk
      assign w_rd = w_dn;
    end
`endif

    always_comb begin
      w_d = w_cur;
      unique case (1'b1)
        w_shu:   w_d = w_up;
        w_shd:   w_d = w_dn;
        w_ld:    w_d = load_i[k*W +: W];
        w_clr:   w_d = reset_val_p[k*W +: W];
`ifdef SHIFT_UNIVERSAL_ROTATE_EN
        w_rou:   w_d = w_ru;
        w_rod:   w_d = w_rd;
`endif
        default: w_d = w_cur;
      endcase
    end

    dff_vec #(
      .width_p     (W),
      .reset_val_p (reset_val_p[k*W +: W])
    ) u_stage (
      .clk_i     (clk_i),
      .reset_n_i (reset_n_i),
      .en_i      (w_en),
      .d_i       (w_d),
      .q_o       (w_q[k*W +: W])
    );
  end

  // Fill counts writes since reset/clear/load and never wraps.
  always_comb begin
    w_fill_nxt = r_fill;
    if (w_shu || w_shd) begin
      if (r_fill != FULL) begin
        w_fill_nxt = r_fill + 1'b1;
      end
    end else if (w_ld) begin
      w_fill_nxt = FULL;
    end else if (w_clr) begin
      w_fill_nxt = '0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      r_fill <= '0;
    end else begin
      r_fill <= w_fill_nxt;
    end
  end

  assign data_o      = w_q;
  assign serial_lo_o = w_q[0 +: W];
  assign serial_hi_o = w_q[TOP*W +: W];
  assign fill_o      = r_fill;
  assign full_o      = (r_fill == FULL);

endmodule

// File: tb/tb_shift_universal.sv
// tb_shift_universal: directed and random checks of shift_universal
// (depth 4 and depth 1) against a packed-word reference model.
module tb_shift_universal;

  localparam logic [31:0] RV = 32'h0403_0201;
`ifdef SHIFT_UNIVERSAL_ROTATE_EN
  localparam bit ROT = 1'b1;
`else
  localparam bit ROT = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [2:0]  mode = 3'd0;
  logic [7:0]  s_lo = 8'h00;
  logic [7:0]  s_hi = 8'h00;
  logic [31:0] ld = 32'h0;

  logic [31:0] d4;
  logic [7:0]  lo4, hi4;
  logic [2:0]  fill4;
  logic        full4;
  logic [7:0]  d1, lo1, hi1;
  logic [0:0]  fill1;
  logic        full1;

  logic [31:0] m_d;
  int          m_f;
  logic [7:0]  m1_d;
  int          m1_f;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  shift_universal #(
    .width_p(8), .depth_p(4), .reset_val_p(RV)
  ) dut (
    .clk_i(clk), .reset_n_i(rst_n), .mode_i(mode),
    .serial_lo_i(s_lo), .serial_hi_i(s_hi), .load_i(ld),
    .data_o(d4), .serial_lo_o(lo4), .serial_hi_o(hi4),
    .fill_o(fill4), .full_o(full4)
  );

  shift_universal #(
    .width_p(8), .depth_p(1), .reset_val_p(8'h00)
  ) dut1 (
    .clk_i(clk), .reset_n_i(rst_n), .mode_i(mode),
    .serial_lo_i(s_lo), .serial_hi_i(s_hi), .load_i(ld[7:0]),
    .data_o(d1), .serial_lo_o(lo1), .serial_hi_o(hi1),
    .fill_o(fill1), .full_o(full1)
  );

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  function automatic int sat(input int v, input int mx);
    return (v > mx) ? mx : v;
  endfunction

  task automatic model(input logic r, input logic [2:0] md);
    if (!r) begin
      m_d = RV;  m_f = 0;
      m1_d = 8'h00; m1_f = 0;
    end else begin
      case (md)
        3'd1: begin
          m_d = (m_d << 8) | {24'h0, s_lo};
          m_f = sat(m_f + 1, 4);
          m1_d = s_lo; m1_f = 1;
        end
        3'd2: begin
          m_d = (m_d >> 8) | {s_hi, 24'h0};
          m_f = sat(m_f + 1, 4);
          m1_d = s_hi; m1_f = 1;
        end
        3'd3: begin
          m_d = ld; m_f = 4;
          m1_d = ld[7:0]; m1_f = 1;
        end
        3'd4: if (ROT) m_d = (m_d << 8) | (m_d >> 24);
        3'd5: if (ROT) m_d = (m_d >> 8) | (m_d << 24);
        3'd6: begin
          m_d = RV; m_f = 0;
          m1_d = 8'h00; m1_f = 0;
        end
        default: ;
      endcase
    end
  endtask

  task automatic cmp_all();
    chk("data4", 64'(d4), 64'(m_d));
    chk("lo4",   64'(lo4), 64'(m_d[7:0]));
    chk("hi4",   64'(hi4), 64'(m_d[31:24]));
    chk("fill4", 64'(fill4), 64'(m_f));
    chk("full4", 64'(full4), 64'(m_f == 4));
    chk("data1", 64'(d1), 64'(m1_d));
    chk("lo1",   64'(lo1), 64'(m1_d));
    chk("hi1",   64'(hi1), 64'(m1_d));
    chk("fill1", 64'(fill1), 64'(m1_f));
    chk("full1", 64'(full1), 64'(m1_f == 1));
  endtask

  task automatic step(input logic r, input logic [2:0] md,
                      input logic [7:0] lo, input logic [7:0] hi,
                      input logic [31:0] l);
    rst_n = r; mode = md; s_lo = lo; s_hi = hi; ld = l;
    @(posedge clk);
    model(r, md);
    #1;
    cmp_all();
  endtask

  initial begin
    m_d = 32'h0; m_f = 0; m1_d = 8'h0; m1_f = 0;

    step(1'b0, 3'd0, 8'h00, 8'h00, 32'h0);
    chk("rst_data", 64'(d4), 64'(RV));
    chk("rst_fill", 64'(fill4), 64'd0);
    chk("rst_full", 64'(full4), 64'd0);

    step(1'b1, 3'd1, 8'hAA, 8'h00, 32'h0);
    chk("up_f1", 64'(fill4), 64'd1);
    step(1'b1, 3'd1, 8'hBB, 8'h00, 32'h0);
    chk("up_f2", 64'(fill4), 64'd2);
    step(1'b1, 3'd1, 8'hCC, 8'h00, 32'h0);
    chk("up_f3", 64'(fill4), 64'd3);
    step(1'b1, 3'd1, 8'hDD, 8'h00, 32'h0);
    chk("up4", 64'(d4), 64'hAABB_CCDD);
    chk("up_full", 64'(full4), 64'd1);
    step(1'b1, 3'd1, 8'hEE, 8'h00, 32'h0);
    chk("up5", 64'(d4), 64'hBBCC_DDEE);
    chk("up5_fill", 64'(fill4), 64'd4);

    step(1'b0, 3'd1, 8'h12, 8'h00, 32'h0);
    chk("rst2_data", 64'(d4), 64'(RV));
    chk("rst2_fill", 64'(fill4), 64'd0);

    step(1'b1, 3'd3, 8'h00, 8'h00, 32'h1122_3344);
    step(1'b1, 3'd2, 8'h00, 8'h55, 32'h0);
    chk("dn", 64'(d4), 64'h5511_2233);
    chk("dn_lo", 64'(lo4), 64'h33);
    chk("dn_fill", 64'(fill4), 64'd4);
    chk("d1_dn", 64'(lo1), 64'h55);

    step(1'b1, 3'd3, 8'h00, 8'h00, 32'h1122_3344);
    step(1'b1, 3'd4, 8'h00, 8'h00, 32'h0);
    chk("rot_up", 64'(d4), ROT ? 64'h2233_4411 : 64'h1122_3344);
    step(1'b1, 3'd5, 8'h00, 8'h00, 32'h0);
    chk("rot_dn", 64'(d4), 64'h1122_3344);
    chk("rot_fill", 64'(fill4), 64'd4);

    step(1'b1, 3'd6, 8'h00, 8'h00, 32'h0);
    chk("clr", 64'(d4), 64'(RV));
    chk("clr_fill", 64'(fill4), 64'd0);
    step(1'b1, 3'd1, 8'h77, 8'h00, 32'h0);
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 3'd7, 8'hFF, 8'hFF, 32'hFFFF_FFFF);
      chk("rsvd", 64'(d4), 64'h0302_0177);
    end

    step(1'b1, 3'd6, 8'h00, 8'h00, 32'h0);
    step(1'b1, 3'd2, 8'h00, 8'h5A, 32'h0);
    chk("d1_lo", 64'(lo1), 64'h5A);
    chk("d1_hi", 64'(hi1), 64'h5A);
    chk("d1_full", 64'(full1), 64'd1);

    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 24) != 0),
           3'($urandom_range(0, 7)),
           8'($urandom), 8'($urandom), 32'($urandom));
    end

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
